// File: rtl/sim_uart_rx.sv
// sim_uart_rx -- receive-side UART for the simulation top.
// Turns the DUT's uart_tx serial stream into bytes and queues them in a small
// first-word-fall-through FIFO. A bench-side valid/ready port drains the FIFO.
// Optional build macros:
//   UART_RX_PARITY_EN : expect an even parity bit between data and stop (8E1).
//   CLOCK_25MHz       : default CLK_HZ becomes 25 MHz instead of 100 MHz.
// CLKS_PER_BIT (CLK_HZ/BAUD) must be at least 8 for the mid-bit sampling to hold.
module sim_uart_rx #(
`ifdef CLOCK_25MHz
    parameter int CLK_HZ     = 25000000,
`else
    parameter int CLK_HZ     = 100000000,
`endif
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          in_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    // $clog2(N) bits are enough to hold N-1, the largest tick reload value
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic sync_meta_reg;
    logic rxs_reg;

    // Two-flop synchronizer; both flops idle high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b1;
            rxs_reg       <= 1'b1;
        end else begin
            sync_meta_reg <= rx;
            rxs_reg       <= sync_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg;
    logic            tick_done;
`ifdef UART_RX_PARITY_EN
    logic            parity_err_reg, parity_err_next;
`endif

    assign tick_done = (tick_reg == '0);

    // State register plus the counters that travel with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            tick_reg       <= '0;
            bit_idx_reg    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            tick_reg       <= tick_next;
            bit_idx_reg    <= bit_idx_next;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Next-state logic: count ticks down to mid-bit, then act on the sampled line
    always_comb begin
        state_next      = state_reg;
        tick_next       = tick_reg;
        bit_idx_next    = bit_idx_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!rxs_reg) begin
                    tick_next  = TICK_HALF;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (!tick_done) begin
                    tick_next = tick_reg - TW'(1);
                end else if (rxs_reg) begin
                    // Line went back high before mid start bit: treat as a glitch
                    state_next = S_IDLE;
                end else begin
                    tick_next       = TICK_FULL;
                    bit_idx_next    = 3'd0;
`ifdef UART_RX_PARITY_EN
                    parity_err_next = 1'b0;
`endif
                    state_next      = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick_done) begin
                    tick_next = tick_reg - TW'(1);
                end else begin
                    tick_next    = TICK_FULL;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick_done) begin
                    tick_next = tick_reg - TW'(1);
                end else begin
                    // Even parity: the parity bit must equal the XOR of the data bits
                    parity_err_next = rxs_reg ^ (^shift_reg);
                    tick_next       = TICK_FULL;
                    state_next      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick_done) begin
                    tick_next = tick_reg - TW'(1);
                end else if (rxs_reg) begin
                    // Back to IDLE mid stop bit so a following start edge is not missed
                    state_next = S_IDLE;
                end else begin
                    state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    logic capture_bit;
    logic stop_sample;
    logic frame_ok;
    logic push;
    logic frame_err_set;

    // Output decode: strobes derived from the current state and tick expiry
    always_comb begin
        capture_bit   = (state_reg == S_DATA) && tick_done;
        stop_sample   = (state_reg == S_STOP) && tick_done;
`ifdef UART_RX_PARITY_EN
        frame_ok      = rxs_reg && !parity_err_reg;
`else
        frame_ok      = rxs_reg;
`endif
        push          = stop_sample && frame_ok;
        frame_err_set = stop_sample && !frame_ok;
    end

    // One flop per data bit, each loaded when its index is sampled (LSB first)
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_reg[gi] <= 1'b0;
                end else if (capture_bit && (bit_idx_reg == 3'(gi))) begin
                    shift_reg[gi] <= rxs_reg;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte FIFO (first-word fall-through via a registered head)
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0] wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [7:0]    head_reg;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic          pop;
    logic          push_ok;
    logic          drop;

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot the same cycle
    always_comb begin
        pop         = (count_reg != '0) && in_ready;
        push_ok     = push && ((count_reg != COUNT_MAX) || pop);
        drop        = push && !push_ok;
        wr_ptr_next = push_ok ? (wr_ptr_reg + AW'(1)) : wr_ptr_reg;
        rd_ptr_next = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;
        count_next  = count_reg + CW'(push_ok) - CW'(pop);
    end

    // Storage array; written only, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Registered read of the next head; bypass the write when it lands on that slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= 8'h00;
        end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= shift_reg;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_err_set;
            overrun_reg   <= drop;
        end
    end

    assign out_data   = head_reg;
    assign out_valid  = (count_reg != '0);
    assign fifo_count = count_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sim_uart_rx.sv
// tb_sim_uart_rx -- directed bench for sim_uart_rx.
// Runs at 32 clocks per bit (CLK_HZ=3686400, BAUD=115200) so that a
// 17-byte overrun sequence fits comfortably in the cycle budget.
// Honours UART_RX_PARITY_EN: frames then carry an even parity bit.
module tb_sim_uart_rx;

    localparam int CLK_HZ     = 3686400;
    localparam int BAUD       = 115200;
    localparam int CPB        = CLK_HZ / BAUD;
    localparam int FIFO_DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // start edge to out_valid: (FRAME_BITS-0.5) bit times plus 3 cycles of sync/detect
    localparam int EXP_LAT = (FRAME_BITS - 1) * CPB + CPB / 2 + 3;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       in_ready;
    logic       frame_err;
    logic       overrun;
    logic [4:0] fifo_count;

    int errors;
    int checks;
    int fe_cnt;
    int ov_cnt;
    int fe0;
    int ov0;
    int lat;

    sim_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count status pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Drive one frame; returns one cycle after the stop bit with the line idle
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {1'b0, stop_bit, d, 1'b0};
        if (par_flip) bits[10] = 1'b0;
`endif
        @(posedge clk);
        for (int i = 0; i < FRAME_BITS; i++) begin
            #1 rx = bits[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
    endtask

    // Check the head entry, then pop it
    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_val({tag, " valid"}, 32'(out_valid), 32'd1);
        check_val(tag, 32'(out_data), 32'(exp));
        in_ready = 1'b1;
        @(posedge clk);
        #1 in_ready = 1'b0;
    endtask

    task automatic check_count(input string tag, input int exp);
        @(negedge clk);
        check_val(tag, 32'(fifo_count), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors   = 0;
        checks   = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        in_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst out_valid",  32'(out_valid),  32'd0);
        check_val("rst out_data",   32'(out_data),   32'd0);
        check_val("rst fifo_count", 32'(fifo_count), 32'd0);
        check_val("rst frame_err",  32'(frame_err),  32'd0);
        check_val("rst overrun",    32'(overrun),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // in_ready while empty does nothing
        #1 in_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_ready = 1'b0;
        @(negedge clk);
        check_val("empty pop count", 32'(fifo_count), 32'd0);
        check_val("empty pop valid", 32'(out_valid),  32'd0);

        // Test 1: single byte and its latency
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                @(posedge clk);
                while (!out_valid && lat < 2 * EXP_LAT) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_val("t1 latency", 32'(lat - 1), 32'(EXP_LAT));
        check_count("t1 count", 1);
        pop_check("t1 byte", 8'h55);
        check_count("t1 count after pop", 0);

        // Test 2: three bytes back to back, then drain in order
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check_count("t2 count", 3);
        pop_check("t2 byte0", 8'h00);
        pop_check("t2 byte1", 8'hFF);
        pop_check("t2 byte2", 8'hA5);
        check_count("t2 count drained", 0);

        // Test 3: short low glitch is ignored
        fe0 = fe_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check_count("t3 glitch count", 0);
        check_val("t3 glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        pop_check("t3 byte after glitch", 8'hC3);

        // Test 4: stop bit low gives a frame error, then recovery
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (FRAME_BITS * CPB) @(posedge clk);
        check_val("t4 frame_err pulses", 32'(fe_cnt - fe0), 32'd1);
        check_count("t4 count after err", 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_val("t4 no extra frame_err", 32'(fe_cnt - fe0), 32'd1);
        pop_check("t4 byte recovered", 8'h3C);

        // Test 5: fill the FIFO, overrun on the 17th byte, drain
        ov0 = ov_cnt;
        for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
        check_count("t5 count full", FIFO_DEPTH);
        check_val("t5 no overrun yet", 32'(ov_cnt - ov0), 32'd0);
        send_frame(8'h10, 1'b1, 1'b0);
        check_val("t5 overrun pulses", 32'(ov_cnt - ov0), 32'd1);
        check_count("t5 count held", FIFO_DEPTH);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_check($sformatf("t5 drain%0d", i), 8'(i));
        check_count("t5 count drained", 0);

`ifdef UART_RX_PARITY_EN
        // Test 6a: parity checking
        fe0 = fe_cnt;
        send_frame(8'h03, 1'b1, 1'b0);
        pop_check("t6 good parity", 8'h03);
        send_frame(8'h03, 1'b1, 1'b1);
        check_val("t6 bad parity frame_err", 32'(fe_cnt - fe0), 32'd1);
        check_count("t6 bad parity count", 0);
`endif

        // Test 6b: reset in the middle of a frame with data queued
        send_frame(8'h81, 1'b1, 1'b0);
        check_count("t6 queued before reset", 1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check_val("t6 rst out_valid",  32'(out_valid),  32'd0);
        check_val("t6 rst out_data",   32'(out_data),   32'd0);
        check_val("t6 rst fifo_count", 32'(fifo_count), 32'd0);
        check_val("t6 rst frame_err",  32'(frame_err),  32'd0);
        check_val("t6 rst overrun",    32'(overrun),    32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * FRAME_BITS * CPB) @(posedge clk);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_count("t6 count after reset", 1);
        pop_check("t6 byte after reset", 8'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
